// File: rtl/decoder_scan_nx_if.sv
// Decoder control/line bus: controller drives en/mode/sel, decoder drives lines.
interface decoder_scan_nx_if #(
    parameter int N = 2
);
    localparam int OUTS = 2 ** N;

    logic            en;
    logic            mode;
    logic [N-1:0]    sel;
    logic [OUTS-1:0] d;
    logic [N-1:0]    idx;
    logic            wrap;

    modport master (output en, mode, sel, input d, idx, wrap);
    modport slave  (input en, mode, sel, output d, idx, wrap);
endinterface

// File: rtl/decoder_scan_nx.sv
// Registered N-to-2^N one-hot decoder with an automatic scan sequencer
// for strobing multiplexed loads (digits, keypad rows).
//
// state  | meaning
// IDLE   | en low or after reset: all lines off, idx holds
// DIRECT | en high, mode 0: line selected by sel, one clock latency
// SCAN   | en high, mode 1: each line held SCAN_DIV clocks, walking 0..OUTS-1
module decoder_scan_nx #(
    parameter int N        = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    decoder_scan_nx_if.slave   bus
);
    localparam int OUTS = 2 ** N;
    localparam int DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [N-1:0]    IDX_LAST = N'(OUTS - 1);
    localparam logic [OUTS-1:0] LINE0    = OUTS'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t          state;
    logic [DW-1:0]   div_q;
    logic [N-1:0]    idx_q;
    logic [OUTS-1:0] d_q;
    logic            wrap_q;
    logic [N-1:0]    idx_step;

    // Natural N-bit overflow gives the modulo-OUTS wrap for free.
    assign idx_step = idx_q + N'(1);

    // State machine and all registered outputs; d is always derived from the
    // index written on the same edge, so it can never be two-hot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            div_q  <= '0;
            idx_q  <= '0;
            d_q    <= '0;
            wrap_q <= 1'b0;
        end else if (!bus.en) begin
            state  <= IDLE;
            div_q  <= '0;
            d_q    <= '0;
            wrap_q <= 1'b0;
        end else if (!bus.mode) begin
            state  <= DIRECT;
            div_q  <= '0;
            idx_q  <= bus.sel;
            d_q    <= LINE0 << bus.sel;
            wrap_q <= 1'b0;
        end else if (state != SCAN) begin
            // Entry edge counts as the first dwell clock of line 0.
            state  <= SCAN;
            div_q  <= '0;
            idx_q  <= '0;
            d_q    <= LINE0;
            wrap_q <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q  <= '0;
            idx_q  <= idx_step;
            d_q    <= LINE0 << idx_step;
            wrap_q <= (idx_q == IDX_LAST);
        end else begin
            div_q  <= div_q + DW'(1);
            wrap_q <= 1'b0;
        end
    end

    assign bus.d    = d_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scan_nx.sv
// Scoreboard bench: instance A (N=2, SCAN_DIV=4), instance B (N=3, SCAN_DIV=1).
module tb_decoder_scan_nx;
    typedef struct packed {
        logic [7:0] d;
        logic [2:0] idx;
        logic       wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b2;
    int   ncmp = 0;
    int   nerr = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // model state per instance: 0 off, 1 direct, 2 scan
    int m_kind[2];
    int m_cnt[2];
    int m_idx[2];

    decoder_scan_nx_if #(.N(2)) bus_a ();
    decoder_scan_nx_if #(.N(3)) bus_b ();

    decoder_scan_nx #(.N(2), .SCAN_DIV(4)) dut_a (.clk(clk), .rst(rst_a),  .bus(bus_a));
    decoder_scan_nx #(.N(3), .SCAN_DIV(1)) dut_b (.clk(clk), .rst(rst_b2), .bus(bus_b));

    always #5 clk = ~clk;

    // Reference: in SCAN the active line is purely a function of clocks spent
    // in scan since entry: line = (t / SCAN_DIV) mod OUTS.
    function automatic exp_t model(input int k, input int outs, input int sd,
                                   input bit r, input bit e, input bit m, input int s);
        exp_t x;
        x = '0;
        if (r) begin
            m_kind[k] = 0;
            m_idx[k]  = 0;
        end else if (!e) begin
            m_kind[k] = 0;
        end else if (!m) begin
            m_kind[k] = 1;
            m_idx[k]  = s;
            x.d       = 8'(1 << s);
        end else begin
            int step;
            if (m_kind[k] != 2) m_cnt[k] = 0;
            else                m_cnt[k] = m_cnt[k] + 1;
            m_kind[k] = 2;
            step      = m_cnt[k] / sd;
            m_idx[k]  = step % outs;
            x.d       = 8'(1 << m_idx[k]);
            x.wrap    = (m_cnt[k] > 0) && (m_cnt[k] % sd == 0) && (step % outs == 0);
        end
        x.idx = 3'(m_idx[k]);
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expectations pushed at each active edge from the inputs the DUT sees.
    always @(posedge clk) begin
        q_a.push_back(model(0, 4, 4, rst_a,  bus_a.en, bus_a.mode, int'(bus_a.sel)));
        q_b.push_back(model(1, 8, 1, rst_b2, bus_b.en, bus_b.mode, int'(bus_b.sel)));
    end

    // Monitor: pop and compare away from the active edge, plus one-hot invariant.
    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            chk("a_d",    int'(bus_a.d),    int'(e.d));
            chk("a_idx",  int'(bus_a.idx),  int'(e.idx));
            chk("a_wrap", int'(bus_a.wrap), int'(e.wrap));
            chk("a_onehot", int'($onehot0(bus_a.d) &&
                (bus_a.d == 4'd0 || bus_a.d == (4'd1 << bus_a.idx))), 1);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            chk("b_d",    int'(bus_b.d),    int'(e.d));
            chk("b_idx",  int'(bus_b.idx),  int'(e.idx));
            chk("b_wrap", int'(bus_b.wrap), int'(e.wrap));
            chk("b_onehot", int'($onehot0(bus_b.d) &&
                (bus_b.d == 8'd0 || bus_b.d == (8'd1 << bus_b.idx))), 1);
        end
    end

    task automatic drive_a(input bit r, input bit e, input bit m, input int s, input int n);
        for (int i = 0; i < n; i++) begin
            rst_a      = r;
            bus_a.en   = e;
            bus_a.mode = m;
            bus_a.sel  = 2'(s);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_a = 1'b1; bus_a.en = 1'b1; bus_a.mode = 1'b1; bus_a.sel = 2'd3;
        rst_b2 = 1'b1; bus_b.en = 1'b1; bus_b.mode = 1'b1; bus_b.sel = 3'd5;
        m_kind = '{0, 0}; m_cnt = '{0, 0}; m_idx = '{0, 0};
        @(negedge clk);
        @(negedge clk);
        rst_b2 = 1'b0;                      // B scans continuously from here
        drive_a(0, 0, 0, 0, 3);             // release with en=0
        for (int s = 0; s < 4; s++) drive_a(0, 1, 0, s, 4);   // direct walk
        drive_a(0, 1, 1, 0, 20);            // scan with wrap
        drive_a(0, 0, 1, 0, 3);             // pause mid-scan
        drive_a(0, 1, 1, 0, 10);            // restart at line 0
        drive_a(1, 1, 1, 0, 1);             // reset mid-scan
        drive_a(0, 1, 1, 0, 6);
        drive_a(0, 1, 0, 2, 2);             // scan -> direct
        drive_a(0, 1, 1, 1, 5);             // direct -> scan
        // randomized runs on both instances
        for (int r = 0; r < 60; r++) begin
            int  len;
            bit  e, m;
            len = $urandom_range(1, 12);
            e   = ($urandom_range(0, 5) != 0);
            m   = $urandom_range(0, 1);
            for (int i = 0; i < len; i++) begin
                rst_a      = ($urandom_range(0, 60) == 0);
                bus_a.en   = e;
                bus_a.mode = m;
                bus_a.sel  = 2'($urandom);
                rst_b2     = ($urandom_range(0, 80) == 0);
                bus_b.en   = ($urandom_range(0, 9) != 0);
                bus_b.mode = ($urandom_range(0, 7) != 0);
                bus_b.sel  = 3'($urandom);
                @(negedge clk);
            end
        end
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
